alu_pipe: RTL and testbench

ALU_PIPE -- requirements
Module: alu_pipe

---
 rtl/alu_pipe.sv | 124 ++++++++++++
 tb/tb_alu_pipe.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/alu_pipe.sv
// Handshaked single-result ALU with registered result/zero flag.
// Define ALU_PIPE_MUL_EN to include the iterative shift-add multiplier (op 1010, CALC state).
module alu_pipe #(
    parameter int XLEN = 32,
    parameter int SHW  = $clog2(XLEN)
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] a,
    input  logic [XLEN-1:0] b,
    input  logic [3:0]      op,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] result,
    output logic            zero,
    output logic            busy
);

    // state | meaning
    // IDLE  | no result held, ready for a request
    // CALC  | multiplier iterating, one multiplier bit per cycle
    // DONE  | result/zero valid, waiting for consumer
    typedef enum logic [1:0] {IDLE, CALC, DONE} stateT;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;

    stateT           state;
    logic [XLEN-1:0] aluOut;
    logic [SHW-1:0]  shamt;
    logic            xfer;
    logic            isMul;

    assign shamt     = b[SHW-1:0];
    assign in_ready  = !rst && ((state == IDLE) || ((state == DONE) && out_ready));
    assign xfer      = in_valid && in_ready;
    assign out_valid = (state == DONE);

    always_comb begin
        aluOut = '0;
        case (op)
            OP_ADD:  aluOut = a + b;
            OP_SUB:  aluOut = a - b;
            OP_AND:  aluOut = a & b;
            OP_OR:   aluOut = a | b;
            OP_XOR:  aluOut = a ^ b;
            OP_SLL:  aluOut = a << shamt;
            OP_SRL:  aluOut = a >> shamt;
            OP_SRA:  aluOut = XLEN'($signed(a) >>> shamt);
            OP_SLT:  aluOut = {{(XLEN-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU: aluOut = {{(XLEN-1){1'b0}}, (a < b)};
            default: aluOut = '0;
        endcase
    end

`ifdef ALU_PIPE_MUL_EN
    localparam int         CW     = $clog2(XLEN) + 1;
    localparam logic [3:0] OP_MUL = 4'b1010;

    logic [XLEN-1:0] mcand;
    logic [XLEN-1:0] mplier;
    logic [CW-1:0]   iterCnt;
    logic [XLEN-1:0] accNext;

    assign isMul   = (op == OP_MUL);
    assign busy    = (state == CALC);
    // result doubles as the accumulator while CALC; it is not observable until DONE
    assign accNext = result + (mplier[0] ? mcand : '0);
`else
    assign isMul = 1'b0;
    assign busy  = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state  <= IDLE;
            result <= '0;
            zero   <= 1'b1;
`ifdef ALU_PIPE_MUL_EN
            mcand   <= '0;
            mplier  <= '0;
            iterCnt <= '0;
`endif
        end else if (xfer) begin
            if (isMul) begin
`ifdef ALU_PIPE_MUL_EN
                state   <= CALC;
                result  <= '0;
                mcand   <= a;
                mplier  <= b;
                iterCnt <= CW'(XLEN);
`endif
            end else begin
                state  <= DONE;
                result <= aluOut;
                zero   <= (aluOut == '0);
            end
        end else if ((state == DONE) && out_ready) begin
            state <= IDLE;
        end else if (state == CALC) begin
`ifdef ALU_PIPE_MUL_EN
            result  <= accNext;
            mcand   <= mcand << 1;
            mplier  <= mplier >> 1;
            iterCnt <= iterCnt - CW'(1);
            if (iterCnt == CW'(1)) begin
                state <= DONE;
                zero  <= (accNext == '0);
            end
`endif
        end
    end

endmodule

// File: tb/tb_alu_pipe.sv
// Directed self-checking bench for alu_pipe (XLEN=32); follows ALU_PIPE_MUL_EN if defined.
module tb_alu_pipe;

    localparam logic [3:0] OP_ADD  = 4'b0000;
    localparam logic [3:0] OP_SLL  = 4'b0001;
    localparam logic [3:0] OP_SUB  = 4'b0010;
    localparam logic [3:0] OP_SRL  = 4'b0011;
    localparam logic [3:0] OP_XOR  = 4'b0100;
    localparam logic [3:0] OP_SRA  = 4'b0101;
    localparam logic [3:0] OP_AND  = 4'b0110;
    localparam logic [3:0] OP_OR   = 4'b0111;
    localparam logic [3:0] OP_SLT  = 4'b1000;
    localparam logic [3:0] OP_SLTU = 4'b1001;
    localparam logic [3:0] OP_MUL  = 4'b1010;
    localparam logic [3:0] OP_BAD  = 4'b1111;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] a;
    logic [31:0] b;
    logic [3:0]  op;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        busy;

    int errCount   = 0;
    int checkCount = 0;

    alu_pipe #(.XLEN(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .op        (op),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checkCount++;
        if (obs !== exp) begin
            errCount++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1 with the DUT idle and out_ready=1; returns at posedge+1, idle again.
    task automatic runOp(input string tag, input logic [3:0] o, input logic [31:0] x,
                         input logic [31:0] y, input logic [31:0] expRes);
        op = o; a = x; b = y; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'hDEADBEEF; b = 32'h0000_0007;
        @(negedge clk);
        check({tag, ".valid"}, out_valid, 1);
        check({tag, ".result"}, result, expRes);
        check({tag, ".zero"}, zero, (expRes == 32'h0));
        @(posedge clk); #1;
    endtask

    initial begin
        logic sawValid;
        rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0; a = '0; b = '0; op = '0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("rst.inReady", in_ready, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("reset.outValid", out_valid, 0);
        check("reset.result", result, 0);
        check("reset.zero", zero, 1);
        check("reset.inReady", in_ready, 1);
        check("reset.busy", busy, 0);
        @(posedge clk); #1;
        out_ready = 1'b1;

        runOp("sub", OP_SUB, 32'd5, 32'd5, 32'h0);
        runOp("sra", OP_SRA, 32'h8000_0000, 32'd4, 32'hF800_0000);
        runOp("slt", OP_SLT, 32'hFFFF_FFFF, 32'd1, 32'h1);
        runOp("sltu", OP_SLTU, 32'hFFFF_FFFF, 32'd1, 32'h0);
        runOp("add", OP_ADD, 32'd3, 32'd4, 32'd7);
        runOp("subWrap", OP_SUB, 32'd0, 32'd1, 32'hFFFF_FFFF);
        runOp("and", OP_AND, 32'h0000_F0F0, 32'h0000_FF00, 32'h0000_F000);
        runOp("xor", OP_XOR, 32'h0000_00FF, 32'h0000_000F, 32'h0000_00F0);
        runOp("sll31", OP_SLL, 32'd1, 32'd31, 32'h8000_0000);
        runOp("sllShamt", OP_SLL, 32'd1, 32'd33, 32'd2);
        runOp("srl", OP_SRL, 32'h8000_0000, 32'd4, 32'h0800_0000);
        runOp("badOp", OP_BAD, 32'h1234_5678, 32'h1, 32'h0);

        // back-to-back stream
        op = OP_ADD; a = 32'd1; b = 32'd1; in_valid = 1'b1;
        @(negedge clk);
        check("b2b.inReady0", in_ready, 1);
        @(posedge clk); #1;
        a = 32'd2; b = 32'd2;
        @(negedge clk);
        check("b2b.valid1", out_valid, 1);
        check("b2b.res1", result, 2);
        check("b2b.inReady1", in_ready, 1);
        @(posedge clk); #1;
        a = 32'd3; b = 32'd3;
        @(negedge clk);
        check("b2b.valid2", out_valid, 1);
        check("b2b.res2", result, 4);
        check("b2b.inReady2", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b.valid3", out_valid, 1);
        check("b2b.res3", result, 6);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b.drained", out_valid, 0);
        @(posedge clk); #1;

        // backpressure hold with a second request waiting
        out_ready = 1'b0;
        op = OP_OR; a = 32'h0000_00F0; b = 32'h0000_000F; in_valid = 1'b1;
        @(posedge clk); #1;
        op = OP_ADD; a = 32'd10; b = 32'd20;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("hold.valid", out_valid, 1);
            check("hold.result", result, 32'hFF);
            check("hold.zero", zero, 0);
            check("hold.inReady", in_ready, 0);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("release.inReady", in_ready, 1);
        check("release.result", result, 32'hFF);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("second.valid", out_valid, 1);
        check("second.result", result, 32'd30);
        @(posedge clk); #1;

`ifdef ALU_PIPE_MUL_EN
        op = OP_MUL; a = 32'hFFFF_FFFF; b = 32'd3; in_valid = 1'b1;
        @(negedge clk);
        check("mul.inReady", in_ready, 1);
        @(posedge clk); #1;
        in_valid = 1'b0; a = 32'h1234_5678; b = 32'd9;
        for (int i = 1; i <= 32; i++) begin
            @(negedge clk);
            check("mul.busy", busy, 1);
            check("mul.earlyValid", out_valid, 0);
            check("mul.inReadyCalc", in_ready, 0);
            @(posedge clk); #1;
        end
        @(negedge clk);
        check("mul.valid", out_valid, 1);
        check("mul.busyDone", busy, 0);
        check("mul.result", result, 32'hFFFF_FFFD);
        check("mul.zero", zero, 0);
        @(posedge clk); #1;

        op = OP_MUL; a = 32'hFFFF_FFFF; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst = 1'b1;
        @(negedge clk);
        check("abort.inReadyRst", in_ready, 0);
        check("abort.busyBefore", busy, 1);
        @(posedge clk); #1;
        rst = 1'b0;
        sawValid = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (out_valid) sawValid = 1'b1;
        end
        check("abort.noValid", sawValid, 0);
        check("abort.busy", busy, 0);
        check("abort.inReady", in_ready, 1);
        check("abort.result", result, 0);
`else
        op = OP_MUL; a = 32'hFFFF_FFFF; b = 32'd3; in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("noMul.valid", out_valid, 1);
        check("noMul.result", result, 0);
        check("noMul.zero", zero, 1);
        check("noMul.busy", busy, 0);
        @(posedge clk); #1;
`endif

        $display("Result: errors=%0d of %0d checks", errCount, checkCount);
        $finish;
    end

endmodule
